// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and defaults for the FIFO write-port round-robin arbiter.
//   Contents:
//     arb_state_t : arbiter FSM state (IDLE / GRANT)
//     DEF_*       : default parameter values for the arbiter and its finder
//     BCNT_W      : width of the per-grant burst counter
//     wrap_inc    : index increment that wraps at n-1 -> 0
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned DEF_NREQ  = 4;
   localparam int unsigned DEF_IDW   = 2;
   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_BURST = 2;
   localparam int unsigned BCNT_W    = 4;

   // Increment an index modulo n without a divider (n need not be 2^k).
   function automatic int unsigned wrap_inc(input int unsigned idx,
                                            input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin finder. Scans i_start, i_start+1, ... modulo
//   NREQ and returns the first index whose valid bit is set.
//   Ports:
//     i_valid [NREQ] : request vector
//     i_start [IDW]  : index where the scan begins (must be < NREQ)
//     o_found        : at least one request bit is set
//     o_idx   [IDW]  : selected index (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = DEF_NREQ,
   parameter int unsigned IDW  = DEF_IDW
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [IDW-1:0]  i_start,
   output logic            o_found,
   output logic [IDW-1:0]  o_idx
);

   int unsigned w_pos;

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_pos   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         // start + k is below 2*NREQ, so one conditional subtract wraps it.
         w_pos = 32'(i_start) + k;
         if (w_pos >= NREQ) begin
            w_pos = w_pos - NREQ;
         end
         if (!o_found && i_valid[IDW'(w_pos)]) begin
            o_found = 1'b1;
            o_idx   = IDW'(w_pos);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one synchronous FIFO write port among NREQ
//   valid/ready producers. One owner at a time holds the port for up to BURST
//   transfers, then the grant rotates. Every write is gated by fifo_full.
//   Ports:
//     clk          : clock, rising edge
//     rst          : asynchronous active-low reset
//     req_valid    : per-requester word available
//     req_data     : requester i data at [i*WIDTH +: WIDTH]
//     req_ready    : per-requester word accepted (with valid) this cycle
//     fifo_full    : registered full flag from the FIFO
//     fifo_wr_en   : FIFO write enable
//     fifo_wr_data : FIFO write data (owner's slice)
//     grant_active : a requester owns the port (registered)
//     grant_id     : current owner index, 0 when idle (registered)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ  = DEF_NREQ,
   parameter int unsigned IDW   = DEF_IDW,
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned BURST = DEF_BURST
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [WIDTH-1:0]      fifo_wr_data,
   output logic                  grant_active,
   output logic [IDW-1:0]        grant_id
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [IDW-1:0]    r_owner;
   logic [IDW-1:0]    w_owner_nxt;
   logic [IDW-1:0]    r_rr_ptr;
   logic [IDW-1:0]    w_rr_ptr_nxt;
   logic [BCNT_W-1:0] r_burst_cnt;
   logic [BCNT_W-1:0] w_burst_cnt_nxt;

   logic [IDW-1:0]    w_owner_inc;
   logic [IDW-1:0]    w_pick_start;
   logic              w_pick_found;
   logic [IDW-1:0]    w_pick_idx;
   logic              w_granted;
   logic              w_owner_valid;
   logic              w_xfer;
   logic              w_last;
   logic              w_release;

   assign w_granted     = (r_state == GRANT);
   assign w_owner_inc   = IDW'(wrap_inc(32'(r_owner), NREQ));
   assign w_owner_valid = req_valid[r_owner];
   assign w_xfer        = w_granted && w_owner_valid && !fifo_full;
   assign w_last        = (r_burst_cnt == BCNT_W'(BURST - 1));
   // A full stall neither counts toward the burst nor releases the grant;
   // only a completed last transfer or a withdrawn owner does.
   assign w_release     = w_granted && ((w_xfer && w_last) || !w_owner_valid);

   // Single finder: in IDLE the scan starts at rr_ptr, in GRANT it is only
   // consulted on release and starts just past the current owner.
   assign w_pick_start  = w_granted ? w_owner_inc : r_rr_ptr;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .i_valid (req_valid),
      .i_start (w_pick_start),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_burst_cnt_nxt = r_burst_cnt;
      case (r_state)
         IDLE: begin
            if (w_pick_found) begin
               w_state_nxt     = GRANT;
               w_owner_nxt     = w_pick_idx;
               w_burst_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_rr_ptr_nxt = w_owner_inc;
               if (w_pick_found) begin
                  w_owner_nxt     = w_pick_idx;
                  w_burst_cnt_nxt = '0;
               end else begin
                  // Owner cleared so grant_id reads 0 while idle.
                  w_state_nxt     = IDLE;
                  w_owner_nxt     = '0;
                  w_burst_cnt_nxt = '0;
               end
            end else if (w_xfer) begin
               w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_owner_nxt     = '0;
            w_burst_cnt_nxt = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      if (w_granted) begin
         req_ready[r_owner] = !fifo_full;
         fifo_wr_en         = w_xfer;
         fifo_wr_data       = req_data[32'(r_owner) * WIDTH +: WIDTH];
      end
   end

   assign grant_active = w_granted;
   assign grant_id     = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (NREQ=4, WIDTH=4, BURST=2).
//   Producers and an 8-deep FIFO occupancy are modelled in the bench; the
//   expected arbiter behaviour comes from a behavioural grant model.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int IW    = 2;
   localparam int W     = 4;
   localparam int B     = 2;
   localparam int DEPTH = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           fifo_full = 1'b0;
   logic           fifo_wr_en;
   logic [W-1:0]   fifo_wr_data;
   logic           grant_active;
   logic [IW-1:0]  grant_id;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NREQ  (N),
      .IDW   (IW),
      .WIDTH (W),
      .BURST (B)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant_active (grant_active),
      .grant_id     (grant_id)
   );

   // Producer side
   bit           p_valid [N];
   logic [W-1:0] p_data  [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = p_valid[i];
         req_data[i*W +: W] = p_data[i];
      end
   end

   // Behavioural model: who holds the port, where the next idle search
   // starts, how many words the holder has moved in this grant.
   bit m_busy;
   int m_own;
   int m_ptr;
   int m_cnt;

   int f_cnt;          // FIFO occupancy
   bit rd_en;          // FIFO read request for the current cycle
   bit hs [N];         // handshake seen in the last cycle
   bit saw_wr;         // DUT wrote in the last cycle
   int saw_gid;        // DUT grant_id in the last cycle

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int search(input int start);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (p_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_own  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
   endtask

   // One clock cycle: check outputs at the falling edge, step the model,
   // then advance past the rising edge and update FIFO occupancy.
   task automatic cycle();
      bit           e_wr;
      logic [N-1:0] e_rdy;
      logic [W-1:0] e_dat;
      int           f;
      int           rd;
      @(negedge clk);
      e_wr  = m_busy && p_valid[m_own] && !fifo_full;
      e_rdy = '0;
      if (m_busy && !fifo_full) e_rdy[m_own] = 1'b1;
      e_dat = m_busy ? p_data[m_own] : '0;
      chk("wr_en",   32'(fifo_wr_en),   32'(e_wr));
      chk("ready",   32'(req_ready),    32'(e_rdy));
      chk("wr_data", 32'(fifo_wr_data), 32'(e_dat));
      chk("gnt_act", 32'(grant_active), 32'(m_busy));
      chk("gnt_id",  32'(grant_id),     m_busy ? m_own : 0);
      for (int i = 0; i < N; i++) hs[i] = p_valid[i] && e_rdy[i];
      saw_wr  = fifo_wr_en;
      saw_gid = int'(grant_id);
      if (!m_busy) begin
         f = search(m_ptr);
         if (f >= 0) begin
            m_busy = 1'b1;
            m_own  = f;
            m_cnt  = 0;
         end
      end else if ((e_wr && m_cnt == B - 1) || !p_valid[m_own]) begin
         m_ptr = (m_own + 1) % N;
         f = search(m_ptr);
         if (f >= 0) begin
            m_own = f;
            m_cnt = 0;
         end else begin
            m_busy = 1'b0;
            m_own  = 0;
            m_cnt  = 0;
         end
      end else if (e_wr) begin
         m_cnt++;
      end
      rd = (rd_en && f_cnt > 0) ? 1 : 0;
      @(posedge clk);
      #1;
      f_cnt     = f_cnt + (saw_wr ? 1 : 0) - rd;
      fifo_full = (f_cnt >= DEPTH);
   endtask

   // Producer update honouring the hold-until-ready contract.
   task automatic stir(input int mask, input int raise_pct, input int keep_pct);
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            if ($urandom_range(99) < keep_pct) p_data[i] = W'($urandom);
            else                               p_valid[i] = 1'b0;
         end else if (!p_valid[i] && mask[i] &&
                      $urandom_range(99) < raise_pct) begin
            p_valid[i] = 1'b1;
            p_data[i]  = W'($urandom);
         end
      end
   endtask

   // Reset asserted between edges; outputs must clear at once even while
   // requesters stay valid.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_wr_en", 32'(fifo_wr_en),   0);
      chk("rst_ready", 32'(req_ready),    0);
      chk("rst_data",  32'(fifo_wr_data), 0);
      chk("rst_gact",  32'(grant_active), 0);
      chk("rst_gid",   32'(grant_id),     0);
      model_reset();
      f_cnt     = 0;
      fifo_full = 1'b0;
      rd_en     = 1'b0;
      for (int i = 0; i < N; i++) hs[i] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic clear_valid();
      for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
   endtask

   initial begin
      int nwr;
      int first;
      int last;
      int sent;
      int seq [8];
      int exp_seq [8];

      for (int i = 0; i < N; i++) begin
         p_valid[i] = 1'b0;
         p_data[i]  = '0;
      end
      model_reset();

      // Single requester, five words: one cycle of grant latency then five
      // back-to-back writes across burst boundaries.
      do_reset();
      p_valid[0] = 1'b1;
      p_data[0]  = W'($urandom);
      nwr = 0; first = -1; last = -1; sent = 0;
      for (int c = 0; c < 9; c++) begin
         cycle();
         if (saw_wr) begin
            if (first < 0) first = c;
            last = c;
            nwr++;
         end
         if (hs[0]) begin
            sent++;
            if (sent < 5) p_data[0]  = W'($urandom);
            else          p_valid[0] = 1'b0;
         end
      end
      chk("t1_nwr",   nwr,          5);
      chk("t1_first", first,        1);
      chk("t1_span",  last - first, 4);

      // Requesters 0 and 2 always valid: order 0,0,2,2,0,0,2,2 fills the FIFO.
      clear_valid();
      do_reset();
      p_valid[0] = 1'b1; p_data[0] = W'($urandom);
      p_valid[2] = 1'b1; p_data[2] = W'($urandom);
      exp_seq = '{0, 0, 2, 2, 0, 0, 2, 2};
      nwr = 0;
      for (int c = 0; c < 20 && nwr < 8; c++) begin
         cycle();
         if (saw_wr) begin
            seq[nwr] = saw_gid;
            nwr++;
         end
         stir(0, 0, 100);
      end
      chk("t2_nwr", nwr, 8);
      for (int k = 0; k < 8; k++) chk($sformatf("t2_seq%0d", k), seq[k], exp_seq[k]);

      // FIFO now full: writes must stall, then resume for owner 0 after a read.
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("t2_stall", 32'(saw_wr), 0);
         stir(0, 0, 100);
      end
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      chk("t2_rd_stall", 32'(saw_wr), 0);
      stir(0, 0, 100);
      cycle();
      chk("t2_resume_wr", 32'(saw_wr), 1);
      chk("t2_resume_id", saw_gid,     0);
      stir(0, 0, 100);

      // Owner 1 withdraws after one word; the grant passes to 3 on that edge.
      clear_valid();
      do_reset();
      p_valid[1] = 1'b1; p_data[1] = W'($urandom);
      p_valid[3] = 1'b1; p_data[3] = W'($urandom);
      cycle();
      cycle();
      chk("t4_hs", 32'(hs[1]), 1);
      p_valid[1] = 1'b0;
      cycle();
      chk("t4_gid", 32'(grant_id), 3);

      // Reset mid-burst with owner 2 at burst_cnt 1; restart scans from 0.
      clear_valid();
      do_reset();
      p_valid[2] = 1'b1; p_data[2] = W'($urandom);
      cycle();
      cycle();
      chk("t5_hs", 32'(hs[2]), 1);
      p_data[2]  = W'($urandom);
      p_valid[3] = 1'b1; p_data[3] = W'($urandom);
      do_reset();
      cycle();
      chk("t5_regrant", 32'(grant_id), 2);
      chk("t5_gact",    32'(grant_active), 1);

      // Randomised traffic with random FIFO drain.
      clear_valid();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         rd_en = ($urandom_range(99) < 45);
         cycle();
         stir(15, 35, 60);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
